// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit sitting right after the execute ALU.
//
// Accepts one memory operation at a time, runs it on a req/gnt/rvalid
// data bus and returns a single-cycle completion pulse. Loads return the
// lane-aligned, sign/zero-extended result.
//
// Ports:
//   clk, rst_n        core clock (rising edge), async active-low reset
//   req_valid/ready   request handshake from execute
//   req_we            1 = store, 0 = load
//   req_funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr          effective byte address
//   req_wdata         store data (rs2)
//   mem_req/we/addr   bus request, write enable, word-aligned address
//   mem_be/wdata      byte enables, lane-replicated store data
//   mem_gnt           bus accepted the request (looked at only in REQ)
//   mem_rvalid/rdata  read data return (looked at only in WAIT)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         load result, held until the next completion
//   rsp_misaligned    qualifies rsp_valid: access faulted, no bus traffic
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only while idle and never depends
// combinationally on req_valid. The bus side uses mem_req held with
// stable address/data until mem_gnt, then one mem_rvalid per load.
module riscv_lsu #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [WORD_LENGTH-1:0] req_addr,
    input  logic [WORD_LENGTH-1:0] req_wdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic [3:0]             mem_be,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [WORD_LENGTH-1:0] mem_rdata,
    output logic                   rsp_valid,
    output logic [WORD_LENGTH-1:0] rsp_rdata,
    output logic                   rsp_misaligned
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e                 state_q;
    logic                   we_q;
    logic [2:0]             funct3_q;
    logic [WORD_LENGTH-1:0] addr_q;
    logic [3:0]             be_q;
    logic [WORD_LENGTH-1:0] wdata_q;
    logic                   fault_q;
    logic [WORD_LENGTH-1:0] rdata_q;

    // Request decode: byte enables, replicated store data, fault check.
    logic [3:0]             be_d;
    logic [WORD_LENGTH-1:0] wdata_d;
    logic                   fault_d;

    always_comb begin
        be_d    = 4'b0000;
        wdata_d = req_wdata;
        fault_d = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
                fault_d = req_addr[0];
            end
            F3_W: begin
                be_d    = 4'b1111;
                fault_d = |req_addr[1:0];
            end
            default: fault_d = 1'b1;
        endcase
        // Unsigned variants only make sense for loads.
        if (req_we && req_funct3[2]) begin
            fault_d = 1'b1;
        end
    end

    // Load extract: bring the addressed lane down to bit 0, then extend.
    logic [WORD_LENGTH-1:0] shifted;
    logic [WORD_LENGTH-1:0] load_data;

    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            F3_B:    load_data = {{(WORD_LENGTH-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {{(WORD_LENGTH-8){1'b0}}, shifted[7:0]};
            F3_H:    load_data = {{(WORD_LENGTH-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {{(WORD_LENGTH-16){1'b0}}, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        be_q     <= be_d;
                        wdata_q  <= wdata_d;
                        fault_q  <= fault_d;
                        if (fault_d) begin
                            rdata_q <= '0;
                            state_q <= RESP;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (we_q) begin
                            rdata_q <= '0;
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= load_data;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic in_req;
    assign in_req = (state_q == REQ);

    // Bus outputs are driven only while requesting, zero otherwise.
    assign req_ready      = (state_q == IDLE);
    assign mem_req        = in_req;
    assign mem_we         = in_req & we_q;
    assign mem_addr       = in_req ? {addr_q[WORD_LENGTH-1:2], 2'b00} : '0;
    assign mem_be         = in_req ? be_q : 4'b0000;
    assign mem_wdata      = in_req ? wdata_q : '0;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_misaligned = (state_q == RESP) & fault_q;
    assign rsp_rdata      = rdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;

  riscv_lsu #(.WORD_LENGTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- records, counters, scoreboard ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic        exp_mis;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access size, alignment and lane position computed
  // arithmetically from the ISA rules.
  function automatic vec_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int gd, input int rd);
    vec_t v;
    int size;
    int off;
    logic legal;
    logic [31:0] val;
    logic [31:0] mask;
    size  = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(we && f3[2]) && (off % size == 0);
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gd = gd; v.rd = rd;
    v.exp_mis   = !legal;
    v.exp_maddr = addr & ~32'h3;
    v.exp_be    = 4'(((1 << size) - 1) << off);
    for (int b = 0; b < 4; b++) v.exp_mwdata[8*b +: 8] = 8'(wdata >> (8 * (b % size)));
    if (!legal || we) val = 32'h0;
    else if (size == 4) val = rdata;
    else begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      val  = (rdata >> (8 * off)) & mask;
      if (!f3[2] && val[8*size-1]) val = val | ~mask;
    end
    v.exp_rdata = val;
    v.exp_cyc   = !legal ? 1 : (we ? 2 + gd : 3 + gd + rd);
    return v;
  endfunction

  // ---------------- driver: one full transaction ----------------
  // Starts on the negedge right after the previous response, so calls
  // chained back to back exercise accept-immediately-after-RESP.
  task automatic run_vec(input vec_t v, input string tag);
    logic seen_req, stable, got, mis;
    logic [31:0] maddr, mwd, rdat, exp;
    logic [3:0] be;
    logic mwe;
    int cyc, rsp_cyc, gcnt, rcnt;
    seen_req = 0; stable = 1; got = 0; mis = 0; rdat = 0;
    maddr = 0; mwd = 0; be = 0; mwe = 0; rsp_cyc = -1; gcnt = 0; rcnt = 0;
    exp_q.push_back(v.exp_rdata);
    @(negedge clk);
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, " rsp idle"}, {31'h0, rsp_valid}, 32'h0);
    req_valid = 1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (cyc = 1; cyc <= 40; cyc++) begin
      mem_gnt = 0; mem_rvalid = 0;
      if (rsp_valid) begin
        got = 1; rsp_cyc = cyc; rdat = rsp_rdata; mis = rsp_misaligned;
        break;
      end
      if (mem_req) begin
        if (!seen_req) begin
          seen_req = 1; maddr = mem_addr; be = mem_be; mwd = mem_wdata; mwe = mem_we;
        end else if (maddr !== mem_addr || be !== mem_be || mwd !== mem_wdata || mwe !== mem_we) begin
          stable = 0;
        end
        if (gcnt == v.gd) mem_gnt = 1;
        else gcnt++;
        // stray read data while requesting must be ignored
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
      end else begin
        if (rcnt == v.rd) begin
          mem_rvalid = 1; mem_rdata = v.rdata;
        end else begin
          rcnt++;
          mem_gnt = 1'($urandom);
          mem_rdata = $urandom;
        end
      end
      @(negedge clk);
    end
    mem_gnt = 0; mem_rvalid = 0;
    exp = exp_q.pop_front();
    check({tag, " rsp seen"}, {31'h0, got}, 32'h1);
    if (got) begin
      check({tag, " latency"}, rsp_cyc, v.exp_cyc);
      check({tag, " misaligned"}, {31'h0, mis}, {31'h0, v.exp_mis});
      check({tag, " rdata"}, rdat, exp);
    end
    check({tag, " bus used"}, {31'h0, seen_req}, {31'h0, !v.exp_mis});
    if (seen_req && !v.exp_mis) begin
      check({tag, " mem_addr"}, maddr, v.exp_maddr);
      check({tag, " mem_be"}, {28'h0, be}, {28'h0, v.exp_be});
      check({tag, " mem_we"}, {31'h0, mwe}, {31'h0, v.we});
      check({tag, " bus stable"}, {31'h0, stable}, 32'h1);
      if (v.we) check({tag, " mem_wdata"}, mwd, v.exp_mwdata);
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[13];
  vec_t rv;

  initial begin
    tbl[0]  = '{0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3};
    tbl[1]  = '{0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 3};
    tbl[2]  = '{0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 3};
    tbl[3]  = '{1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 5};
    tbl[4]  = '{0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1};
    tbl[5]  = '{0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1};
    tbl[6]  = '{0, 3'b001, 32'h10E, 32'h0, 32'h80010000, 0, 0, 0, 32'h10C, 4'b1100, 32'h0, 32'hFFFF8001, 3};
    tbl[7]  = '{0, 3'b101, 32'h10E, 32'h0, 32'h80010000, 0, 0, 0, 32'h10C, 4'b1100, 32'h0, 32'h00008001, 3};
    tbl[8]  = '{1, 3'b000, 32'h001, 32'h00000055, 32'h0, 0, 0, 0, 32'h0, 4'b0010, 32'h55555555, 32'h0, 2};
    tbl[9]  = '{1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1, 0, 0, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0, 3};
    tbl[10] = '{1, 3'b101, 32'h010, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1};
    tbl[11] = '{0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1};
    tbl[12] = '{0, 3'b010, 32'h400, 32'h0, 32'h01234567, 2, 2, 0, 32'h400, 4'b1111, 32'h0, 32'h01234567, 7};

    rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset mem_req", {31'h0, mem_req}, 32'h0);
    check("reset mem_be", {28'h0, mem_be}, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset misaligned", {31'h0, rsp_misaligned}, 32'h0);
    rst_n = 1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // result holds after completion while idle
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold rdata", rsp_rdata, 32'h01234567);
      check("hold no rsp", {31'h0, rsp_valid}, 32'h0);
    end

    // reset while waiting for read data; late rvalid must be ignored
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 0;
    check("rst seq mem_req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    check("rst seq wait", {31'h0, mem_req | rsp_valid}, 32'h0);
    rst_n = 0;
    #2;
    check("rst seq ready", {31'h0, req_ready}, 32'h1);
    check("rst seq rdata clr", rsp_rdata, 32'h0);
    #1 rst_n = 1;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rvalid = 0;
      check("rst seq no rsp", {31'h0, rsp_valid}, 32'h0);
      check("rst seq idle", {31'h0, req_ready}, 32'h1);
    end

    // randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      rv = model(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3));
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit directly downstream of the execute ALU. It takes the ALU result as the effective address, plus rs2 store data and funct3, and runs one data-memory transaction on a req/gnt/rvalid bus. For loads it returns the aligned, sign- or zero-extended result to writeback. The core stalls on req_ready and rsp_valid, so at most one access is in flight.

Parameters:
WORD_LENGTH, 32, data and address width; only 32 is supported (byte-lane logic assumes 4 lanes).

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  LSU idle; request accepted when req_valid&&req_ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
req_addr  in  WORD_LENGTH  effective address (ALU output)
req_wdata  in  WORD_LENGTH  store data (rs2)
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  WORD_LENGTH  word address, bits[1:0] forced 0
mem_be  out  4  byte enables
mem_wdata  out  WORD_LENGTH  lane-replicated store data
mem_gnt  in  1  bus accepted request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  WORD_LENGTH  read data, full word
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  WORD_LENGTH  load result
rsp_misaligned  out  1  qualifies rsp_valid: access faulted, no bus traffic

Behaviour:
- Reset (async assert, sync release): state IDLE. req_ready=1. All other outputs 0, including rsp_rdata. Reset mid-transaction aborts silently, with no rsp_valid; a late mem_rvalid after reset is ignored.
- FSM states IDLE, REQ, WAIT, RESP. req_ready=1 only in IDLE.
- IDLE: on accept, register we, funct3, addr[1:0], byte enables and replicated wdata.
  - Fault when funct3 is illegal, H/HU has addr[0]=1, or W has addr[1:0]!=0. A fault goes to RESP with rsp_misaligned=1 and never raises mem_req.
  - Otherwise go to REQ.
- REQ: mem_req=1. mem_addr/mem_we/mem_be/mem_wdata come from registers and stay stable until grant.
  - On mem_gnt, a store goes to RESP and a load goes to WAIT.
  - mem_gnt in the first REQ cycle is legal.
- WAIT: mem_req=0. On mem_rvalid, register the extracted data and go to RESP. mem_rvalid is sampled only in WAIT; mem_gnt is sampled only in REQ.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_misaligned=0 unless faulted. rsp_rdata=0 for stores and faults. rsp_rdata holds its value until the next RESP.
- Byte enables:
  - B/BU: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H/HU: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}.
  - W: be=4'b1111.
- Load extract: shift mem_rdata right by 8*addr[1:0], take the low byte or half, then sign-extend for B/H or zero-extend for BU/HU. W passes through. we=1 with funct3 BU/HU is illegal and faults.
- Minimum latency, counted from the accept cycle as 0 with gnt immediate and rvalid one cycle later:
  - Load: REQ at 1, WAIT at 2, rsp_valid at 3.
  - Store: rsp_valid at 2.
  - Fault: rsp_valid at 1.
- No outputs are combinational from inputs except none. req_ready and mem_* are decoded from state and registers only.
- Back-to-back: the cycle after RESP is IDLE, so a new request can be accepted then.

Test Plan:
- Load W, addr 0x100, gnt immediate, rdata 0xDEADBEEF one cycle later -> mem_addr 0x100, be 1111, rsp_valid at cycle 3, rsp_rdata 0xDEADBEEF, misaligned 0.
- Load B at 0x103 and BU at 0x103, rdata 0x80FF_0000 -> be 1000; B gives 0xFFFFFF80, BU gives 0x00000080.
- Store H, addr 0x202, wdata 0x1234ABCD, gnt held low 3 cycles -> mem_addr 0x200, be 1100, wdata 0xABCDABCD stable through the stall, rsp_valid 1 cycle after gnt, rsp_rdata 0.
- Load W at 0x101, then funct3=011 -> rsp_valid with rsp_misaligned=1 one cycle after accept, mem_req never asserted.
- Load issued, rst_n pulsed low in WAIT, mem_rvalid arrives after release -> state IDLE, req_ready=1, no rsp_valid.
- Two loads back-to-back (LH 0x10E sign, LHU 0x10E), rdata 0x8001_0000 -> 0xFFFF8001 then 0x00008001; second request accepted the cycle after the first rsp_valid.
